judge_scorer: RTL and testbench
===============================

# judge_scorer

Multi-column timing judge and score accumulator for the rhythm-game datapath. Each tick window it grades every column's button press against that column's falling-light position: PERFECT, GOOD, MISS or NONE. It sums the per-column deltas and applies them to a saturating score register, with a combo counter and a win freeze. It sits between the per-column light shifters and the score display/HEX driver, and generalises single-column scoring to N columns with a configurable tick length and score width.

## Interface
- N_COLS, 4, number of columns judged in parallel
- DEPTH, 8, lights per column; index 0 = top (edge), index 1 = target
- TICK_LEN, 16, clock cycles per light step; power of two not required, ≥ 2
- SCORE_W, 8, score width; maximum score = 2^SCORE_W − 1
- COMBO_W, 6, combo counter width
---
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous restart: score, combo, won and tick counter go to 0
- user_input  input  N_COLS  per-column press, level, already debounced
- lights  input  N_COLS*DEPTH  column c occupies bits [c*DEPTH +: DEPTH]
- off_edge  input  N_COLS  column's top light left the field this tick
- score  output  SCORE_W  current total
- score_valid  output  1  one-cycle pulse when score/combo are updated
- combo  output  COMBO_W  consecutive clean-hit ticks
- won  output  1  score reached maximum; level until clear/reset
- tick_end  output  1  high while tick counter == TICK_LEN−1

## Operation
- Tick counter runs 0..TICK_LEN−1 and wraps. It is frozen at 0 while won=1.
- Per column, a sticky press flag sets on user_input. It is cleared on the edge where tick_end=1.
- Evaluation on the tick_end cycle uses pressed = sticky | user_input.
- Top light is the lowest set index of the column.
- Grade per column:
  - PERFECT: pressed and top == 1.
  - GOOD: pressed and top ∈ {0, 2}.
  - MISS: off_edge, or pressed with no lit bit at index ≤ 2.
  - NONE: otherwise.
- off_edge takes priority over PERFECT/GOOD in the same column, giving MISS.
- Points: PERFECT +2, GOOD +1, MISS −2, NONE 0.
- Per-column deltas are summed as signed, width $clog2(3*N_COLS+1)+2.
- New score = clamp(score + sum, 0, 2^SCORE_W−1). There is never any wrap-around.
- Combo:
  - Any MISS sets combo to 0.
  - Otherwise, ≥1 PERFECT/GOOD increments combo, saturating at 2^COMBO_W−1.
  - An all-NONE tick holds combo.
- When the new score equals the maximum, won sets. While won=1, ticks are not evaluated, presses are ignored and score holds.
- Top-level FSM states:
  - PLAY → WON when the clamped score equals the maximum.
  - WON → PLAY on clear.
  - Reset enters PLAY.

## Timing
- Reset values: score=0, combo=0, won=0, score_valid=0, tick_end=0; counter, sticky flags and pipeline registers are 0.
- Stage 1: grades and delta sum are registered on the tick_end edge.
- Stage 2: score, combo, won and score_valid are updated on the following edge.
- Score is visible 2 cycles after the tick_end edge.
- A press in the tick_end cycle counts for the current tick. A press in cycle 0 counts for the next tick.
- clear coincident with a stage-2 update: clear wins.
- Asynchronous reset mid-tick empties the pipeline; any pending delta is discarded.

## Configuration
- JUDGE_COMBO_BONUS_EN defined: PERFECT is worth +3 while combo ≥ 8 (the combo value before the update). The delta width is already sized for +3.
- Undefined: PERFECT is always +2; no compare logic is instantiated.

## Structure
- judge_pkg holds:
  - typedef enum logic [1:0] grade_t {NONE, GOOD, PERFECT, MISS}
  - point constants PTS_GOOD, PTS_PERFECT, PTS_MISS, PTS_BONUS
  - COMBO_BONUS_MIN = 8
- Sub-module column_judge: one per column via generate. It contains the sticky press flag, the top-light priority encoder and the grade output.
- judge_scorer contains the tick counter, delta adder tree, saturation, combo and FSM.

## Test plan
All scenarios use defaults (N_COLS=4, DEPTH=8, TICK_LEN=16, SCORE_W=8).
- Column 0 lights=8'b0000_0100, press at counter=3 → after tick, score=1, combo=1, score_valid pulses once.
- Column 1 lights=8'b0000_0010 pressed, column 2 off_edge=1 in the same tick → score unchanged (+2−2), combo=0.
- score=1, single MISS → score=0, not 255; then a MISS with score=0 → score stays 0.
- score=254, two columns PERFECT → score=255, won=1; further presses give no change until clear, after which score=0 and won=0.
- Press only during the tick_end cycle → counted this tick; press only at counter=0 → counted next tick.
- Reset driven low at counter=9 with a pending delta → outputs 0 immediately; first post-reset tick_end occurs 15 cycles after reset release.
- With JUDGE_COMBO_BONUS_EN: combo=8, PERFECT → +3, combo=9.

Source files
------------

// File: rtl/judge_pkg.sv
// Shared types and point values for the rhythm-game timing judge.
package judge_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        GOOD    = 2'd1,
        PERFECT = 2'd2,
        MISS    = 2'd3
    } grade_t;

    typedef enum logic {
        PLAY = 1'b0,
        WON  = 1'b1
    } state_t;

    localparam int PTS_GOOD        = 1;
    localparam int PTS_PERFECT     = 2;
    localparam int PTS_MISS        = -2;
    localparam int PTS_BONUS       = 3;
    localparam int COMBO_BONUS_MIN = 8;

    function automatic int grade_points(grade_t g, logic bonus);
        case (g)
            GOOD:    return PTS_GOOD;
            PERFECT: return bonus ? PTS_BONUS : PTS_PERFECT;
            MISS:    return PTS_MISS;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/judge_scorer_if.sv
// Judge bus: column stimulus in, score/combo/status out. score_valid is a
// one-cycle strobe with no backpressure; the consumer must take it when high.
interface judge_scorer_if #(
    parameter int N_COLS  = 4,
    parameter int DEPTH   = 8,
    parameter int SCORE_W = 8,
    parameter int COMBO_W = 6
);
    import judge_pkg::*;

    logic                      clear;
    logic [N_COLS-1:0]         user_input;
    logic [N_COLS*DEPTH-1:0]   lights;
    logic [N_COLS-1:0]         off_edge;
    logic [SCORE_W-1:0]        score;
    logic                      score_valid;
    logic [COMBO_W-1:0]        combo;
    logic                      won;
    logic                      tick_end;
    state_t                    state_dbg;

    modport master (
        output clear, user_input, lights, off_edge,
        input  score, score_valid, combo, won, tick_end, state_dbg
    );

    modport slave (
        input  clear, user_input, lights, off_edge,
        output score, score_valid, combo, won, tick_end, state_dbg
    );
endinterface

// File: rtl/column_judge.sv
// One column: sticky press flag, top-light priority encoder and the grade
// for the current tick window (combinational, registered by the scorer).
module column_judge
    import judge_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             press_i,
    input  logic [DEPTH-1:0] lights_i,
    input  logic             off_edge_i,
    output grade_t           grade_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          sticky_q;
    logic          pressed;
    logic [IW-1:0] top;
    logic          lit;

    // Clear beats set: a press in the tick_end cycle is already folded into
    // this tick's grade through press_i, so it must not leak into the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_q <= 1'b0;
        end else if (clr_i) begin
            sticky_q <= 1'b0;
        end else if (en_i && press_i) begin
            sticky_q <= 1'b1;
        end
    end

    always_comb begin
        top = '0;
        lit = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (lights_i[i]) begin
                top = IW'(i);
                lit = 1'b1;
            end
        end
    end

    always_comb begin
        pressed = sticky_q | press_i;
        grade_o = NONE;
        if (off_edge_i) begin
            grade_o = MISS;
        end else if (pressed) begin
            if (lit && top == IW'(1)) begin
                grade_o = PERFECT;
            end else if (lit && (top == IW'(0) || top == IW'(2))) begin
                grade_o = GOOD;
            end else begin
                grade_o = MISS;
            end
        end
    end
endmodule

// File: rtl/judge_scorer.sv
// N-column judge: tick counter, delta sum, saturating score, combo, win FSM.
// Optional JUDGE_COMBO_BONUS_EN makes PERFECT worth more on a long combo.
module judge_scorer
    import judge_pkg::*;
#(
    parameter int N_COLS   = 4,
    parameter int DEPTH    = 8,
    parameter int TICK_LEN = 16,
    parameter int SCORE_W  = 8,
    parameter int COMBO_W  = 6
) (
    input  logic           clk,
    input  logic           reset,
    judge_scorer_if.slave  bus
);
    localparam int CW = (TICK_LEN > 1) ? $clog2(TICK_LEN) : 1;
    localparam int DW = $clog2(3 * N_COLS + 1) + 2;
    localparam int EW = SCORE_W + DW + 1;

    localparam logic [SCORE_W-1:0]    SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0]    COMBO_MAX = '1;
    localparam logic signed [EW-1:0]  SCORE_MAX_EXT = {{(EW - SCORE_W){1'b0}}, SCORE_MAX};

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   won_q;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [COMBO_W-1:0]     combo_q, combo_d;
    logic                   score_valid_q;
    logic                   s1_valid_q;
    logic signed [DW-1:0]   sum_q, sum_d;
    logic                   miss_q, hit_q;
    logic                   any_miss, any_hit;
    logic                   tick_end;
    logic                   bonus;
    logic                   col_en;
    logic                   col_clr;
    logic signed [EW-1:0]   ext;
    grade_t                 grade [N_COLS];

    assign tick_end = (cnt_q == CW'(TICK_LEN - 1));
    assign col_en   = !won_q;
    assign col_clr  = tick_end | bus.clear;

`ifdef JUDGE_COMBO_BONUS_EN
    assign bonus = (combo_q >= COMBO_W'(COMBO_BONUS_MIN));
`else
    assign bonus = 1'b0;
`endif

    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        column_judge #(.DEPTH(DEPTH)) u_col (
            .clk        (clk),
            .reset      (reset),
            .en_i       (col_en),
            .clr_i      (col_clr),
            .press_i    (bus.user_input[c]),
            .lights_i   (bus.lights[c*DEPTH +: DEPTH]),
            .off_edge_i (bus.off_edge[c]),
            .grade_o    (grade[c])
        );
    end

    always_comb begin
        sum_d    = '0;
        any_miss = 1'b0;
        any_hit  = 1'b0;
        for (int c = 0; c < N_COLS; c++) begin
            sum_d = sum_d + DW'(grade_points(grade[c], bonus));
            if (grade[c] == MISS) any_miss = 1'b1;
            if (grade[c] == GOOD || grade[c] == PERFECT) any_hit = 1'b1;
        end
    end

    // Score is widened before adding so the clamp sees the true signed total.
    always_comb begin
        ext = $signed({{(EW - SCORE_W){1'b0}}, score_q}) + EW'(sum_q);
        if (ext[EW-1]) begin
            score_d = '0;
        end else if (ext > SCORE_MAX_EXT) begin
            score_d = SCORE_MAX;
        end else begin
            score_d = ext[SCORE_W-1:0];
        end

        combo_d = combo_q;
        if (miss_q) begin
            combo_d = '0;
        end else if (hit_q && combo_q != COMBO_MAX) begin
            combo_d = combo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= PLAY;
            cnt_q         <= '0;
            won_q         <= 1'b0;
            score_q       <= '0;
            combo_q       <= '0;
            score_valid_q <= 1'b0;
            s1_valid_q    <= 1'b0;
            sum_q         <= '0;
            miss_q        <= 1'b0;
            hit_q         <= 1'b0;
        end else begin
            score_valid_q <= 1'b0;
            if (bus.clear) begin
                state_q    <= PLAY;
                cnt_q      <= '0;
                won_q      <= 1'b0;
                score_q    <= '0;
                combo_q    <= '0;
                s1_valid_q <= 1'b0;
                sum_q      <= '0;
                miss_q     <= 1'b0;
                hit_q      <= 1'b0;
            end else begin
                if (state_q == WON || tick_end) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end

                s1_valid_q <= tick_end && (state_q == PLAY);
                if (tick_end) begin
                    sum_q  <= sum_d;
                    miss_q <= any_miss;
                    hit_q  <= any_hit;
                end

                if (s1_valid_q) begin
                    score_q       <= score_d;
                    combo_q       <= combo_d;
                    score_valid_q <= 1'b1;
                    if (score_d == SCORE_MAX) begin
                        state_q <= WON;
                        won_q   <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
            end
        end
    end

    assign bus.score       = score_q;
    assign bus.score_valid = score_valid_q;
    assign bus.combo       = combo_q;
    assign bus.won         = won_q;
    assign bus.tick_end    = tick_end;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_judge_scorer.sv
// Self-checking bench for judge_scorer against a tick-level scoring model.
module tb_judge_scorer;
  localparam int N_COLS = 4, DEPTH = 8, TICK_LEN = 16, SCORE_W = 8, COMBO_W = 6;
  localparam int SMAX = 255, CMAX = 63;
`ifdef JUDGE_COMBO_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  judge_scorer_if #(.N_COLS(N_COLS), .DEPTH(DEPTH), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)) bus();
  judge_scorer #(.N_COLS(N_COLS), .DEPTH(DEPTH), .TICK_LEN(TICK_LEN), .SCORE_W(SCORE_W),
                 .COMBO_W(COMBO_W)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int m_score = 0;
  int m_combo = 0;
  logic [SCORE_W-1:0] exp_q[$];
  logic [COMBO_W-1:0] exp_combo_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: one tick window graded from the game rules
  task automatic model_tick(input logic [31:0] lt, input logic [3:0] pressed, input logic [3:0] oe);
    int sum;
    int top;
    bit miss;
    bit hit;
    sum = 0; miss = 0; hit = 0;
    for (int c = 0; c < N_COLS; c++) begin
      top = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (lt[c*DEPTH+i]) top = i;
      if (oe[c]) begin
        sum -= 2; miss = 1;
      end else if (pressed[c]) begin
        if (top == 1) begin
          sum += (BONUS && m_combo >= 8) ? 3 : 2; hit = 1;
        end else if (top == 0 || top == 2) begin
          sum += 1; hit = 1;
        end else begin
          sum -= 2; miss = 1;
        end
      end
    end
    m_score = m_score + sum;
    if (m_score < 0) m_score = 0;
    if (m_score > SMAX) m_score = SMAX;
    if (miss) m_combo = 0;
    else if (hit && m_combo < CMAX) m_combo = m_combo + 1;
    exp_q.push_back(SCORE_W'(m_score));
    exp_combo_q.push_back(COMBO_W'(m_combo));
  endtask

  function automatic logic [7:0] rand_col();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1, 2: return 8'(1 << $urandom_range(0, 7));
      default: return 8'($urandom);
    endcase
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sync_tick_start();
    int n;
    n = 0;
    while (bus.tick_end !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++;
    if (bus.tick_end !== 1'b1) begin
      errors++;
      $display("FAIL sync_timeout: tick_end=%b after %0d cycles, required 1", bus.tick_end, n);
    end
    step(1);
  endtask

  task automatic play_tick(input logic [31:0] lt, input logic [3:0] mask, input int press_at,
                           input logic [3:0] oe, output logic [7:0] o_score, output logic [5:0] o_combo,
                           output logic o_v1, output logic o_v2, output logic o_won);
    sync_tick_start();
    for (int c = 0; c < TICK_LEN; c++) begin
      bus.lights     = lt;
      bus.user_input = (c == press_at) ? mask : 4'b0;
      bus.off_edge   = (c == TICK_LEN - 1) ? oe : 4'b0;
      step(1);
    end
    bus.lights = '0; bus.user_input = '0; bus.off_edge = '0;
    step(1);
    o_score = bus.score; o_combo = bus.combo; o_v1 = bus.score_valid; o_won = bus.won;
    step(1);
    o_v2 = bus.score_valid;
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if (bus.score !== 8'd0 || bus.combo !== 6'd0 || bus.won !== 1'b0 ||
        bus.score_valid !== 1'b0 || bus.tick_end !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: score=%0d combo=%0d won=%b valid=%b tick_end=%b, required all 0",
               bus.score, bus.combo, bus.won, bus.score_valid, bus.tick_end);
    end
    checks++;
    if (bus.state_dbg !== judge_pkg::PLAY) begin
      errors++;
      $display("FAIL reset_state: state=%0d required PLAY", bus.state_dbg);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_good_single();
    logic [7:0] s; logic [5:0] c; logic v1, v2, w;
    play_tick(32'h0000_0004, 4'b0001, 3, 4'b0000, s, c, v1, v2, w);
    model_tick(32'h0000_0004, 4'b0001, 4'b0000);
    void'(exp_q.pop_front()); void'(exp_combo_q.pop_front());
    checks++; if (s !== 8'd1) begin errors++; $display("FAIL good_score: got %0d required 1", s); end
    checks++; if (c !== 6'd1) begin errors++; $display("FAIL good_combo: got %0d required 1", c); end
    checks++; if (v1 !== 1'b1 || v2 !== 1'b0) begin
      errors++; $display("FAIL good_valid_pulse: got %b%b required 10", v1, v2);
    end
  endtask

  task automatic test_perfect_vs_miss();
    logic [7:0] s; logic [5:0] c; logic v1, v2, w;
    play_tick(32'h0000_0200, 4'b0010, 6, 4'b0100, s, c, v1, v2, w);
    model_tick(32'h0000_0200, 4'b0010, 4'b0100);
    void'(exp_q.pop_front()); void'(exp_combo_q.pop_front());
    checks++; if (s !== 8'd1) begin errors++; $display("FAIL pm_score: got %0d required 1", s); end
    checks++; if (c !== 6'd0) begin errors++; $display("FAIL pm_combo: got %0d required 0", c); end
  endtask

  task automatic test_floor();
    logic [7:0] s; logic [5:0] c; logic v1, v2, w;
    play_tick(32'h0000_0080, 4'b0001, 2, 4'b0000, s, c, v1, v2, w);
    model_tick(32'h0000_0080, 4'b0001, 4'b0000);
    void'(exp_q.pop_front()); void'(exp_combo_q.pop_front());
    checks++; if (s !== 8'd0) begin errors++; $display("FAIL floor_from_1: got %0d required 0", s); end
    play_tick(32'h0000_0000, 4'b0000, 0, 4'b1000, s, c, v1, v2, w);
    model_tick(32'h0000_0000, 4'b0000, 4'b1000);
    void'(exp_q.pop_front()); void'(exp_combo_q.pop_front());
    checks++; if (s !== 8'd0) begin errors++; $display("FAIL floor_at_0: got %0d required 0", s); end
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL floor_valid: got %b required 1", v1); end
  endtask

  task automatic test_press_window();
    logic [7:0] s, es; logic [5:0] c; logic v1, v2, w;
    play_tick(32'h0000_0002, 4'b0001, 15, 4'b0000, s, c, v1, v2, w);
    model_tick(32'h0000_0002, 4'b0001, 4'b0000);
    es = exp_q.pop_front(); void'(exp_combo_q.pop_front());
    checks++; if (s !== es) begin errors++; $display("FAIL press_tick_end: got %0d required %0d", s, es); end
    sync_tick_start();
    bus.lights = 32'h0000_0002;
    step(16);
    bus.user_input = 4'b0001;
    step(1);
    bus.user_input = 4'b0000;
    model_tick(32'h0000_0002, 4'b0000, 4'b0000);
    es = exp_q.pop_front(); void'(exp_combo_q.pop_front());
    checks++; if (bus.score_valid !== 1'b1 || bus.score !== es) begin
      errors++; $display("FAIL press_cnt0_excluded: valid=%b score=%0d required 1/%0d", bus.score_valid, bus.score, es);
    end
    step(16);
    model_tick(32'h0000_0002, 4'b0001, 4'b0000);
    es = exp_q.pop_front(); void'(exp_combo_q.pop_front());
    checks++; if (bus.score_valid !== 1'b1 || bus.score !== es) begin
      errors++; $display("FAIL press_cnt0_next_tick: valid=%b score=%0d required 1/%0d", bus.score_valid, bus.score, es);
    end
    bus.lights = '0;
  endtask

  task automatic test_random();
    logic [7:0] s, es; logic [5:0] c, ec; logic v1, v2, w;
    logic [31:0] lt; logic [3:0] mask, oe;
    for (int t = 0; t < 16; t++) begin
      lt = {rand_col(), rand_col(), rand_col(), rand_col()};
      mask = 4'($urandom);
      oe = 4'($urandom & $urandom);
      play_tick(lt, mask, $urandom_range(0, TICK_LEN - 1), oe, s, c, v1, v2, w);
      model_tick(lt, mask, oe);
      es = exp_q.pop_front(); ec = exp_combo_q.pop_front();
      checks++; if (s !== es || c !== ec || v1 !== 1'b1) begin
        errors++;
        $display("FAIL random_tick%0d: score=%0d combo=%0d valid=%b required %0d/%0d/1 (lt=%h m=%b oe=%b)",
                 t, s, c, v1, es, ec, lt, mask, oe);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] s, es; logic [5:0] c; logic v1, v2, w;
    int n;
    play_tick(32'h0000_0001, 4'b0001, 1, 4'b0000, s, c, v1, v2, w);
    model_tick(32'h0000_0001, 4'b0001, 4'b0000);
    es = exp_q.pop_front(); void'(exp_combo_q.pop_front());
    checks++; if (s !== es) begin errors++; $display("FAIL prereset_score: got %0d required %0d", s, es); end
    sync_tick_start();
    bus.lights = 32'h0000_0002;
    step(3);
    bus.user_input = 4'b0001;
    step(1);
    bus.user_input = 4'b0000;
    step(5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.score !== 8'd0 || bus.combo !== 6'd0 || bus.won !== 1'b0 ||
        bus.score_valid !== 1'b0 || bus.tick_end !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: score=%0d combo=%0d won=%b valid=%b tick_end=%b, required all 0",
               bus.score, bus.combo, bus.won, bus.score_valid, bus.tick_end);
    end
    step(2);
    rst_n = 1'b1;
    m_score = 0; m_combo = 0;
    n = 0;
    while (bus.tick_end !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL first_tick_end: got %0d cycles required 15", n); end
    step(2);
    model_tick(32'h0000_0002, 4'b0000, 4'b0000);
    es = exp_q.pop_front(); void'(exp_combo_q.pop_front());
    checks++; if (bus.score_valid !== 1'b1 || bus.score !== es) begin
      errors++; $display("FAIL pending_discarded: valid=%b score=%0d required 1/%0d", bus.score_valid, bus.score, es);
    end
    bus.lights = '0;
  endtask

  task automatic test_win();
    logic [7:0] s, es; logic [5:0] c, ec; logic v1, v2, w;
    int k;
    logic [3:0] mask;
    while (m_score < 254) begin
      k = (254 - m_score >= 4) ? 4 : 254 - m_score;
      mask = 4'((1 << k) - 1);
      play_tick(32'h0101_0101, mask, 5, 4'b0000, s, c, v1, v2, w);
      model_tick(32'h0101_0101, mask, 4'b0000);
      es = exp_q.pop_front(); ec = exp_combo_q.pop_front();
      checks++; if (s !== es || c !== ec) begin
        errors++; $display("FAIL fill_tick: score=%0d combo=%0d required %0d/%0d", s, c, es, ec);
      end
    end
    play_tick(32'h0202_0202, 4'b0011, 7, 4'b0000, s, c, v1, v2, w);
    model_tick(32'h0202_0202, 4'b0011, 4'b0000);
    void'(exp_q.pop_front()); void'(exp_combo_q.pop_front());
    checks++; if (s !== 8'd255 || w !== 1'b1) begin
      errors++; $display("FAIL win_reach: score=%0d won=%b required 255/1", s, w);
    end
    checks++; if (bus.state_dbg !== judge_pkg::WON) begin
      errors++; $display("FAIL win_state: state=%0d required WON", bus.state_dbg);
    end
    bus.lights = 32'h0202_0202;
    for (int i = 0; i < 40; i++) begin
      bus.user_input = 4'($urandom);
      step(1);
      checks++;
      if (bus.score !== 8'd255 || bus.won !== 1'b1 || bus.tick_end !== 1'b0 || bus.score_valid !== 1'b0) begin
        errors++;
        $display("FAIL won_frozen: cycle %0d score=%0d won=%b tick_end=%b valid=%b required 255/1/0/0",
                 i, bus.score, bus.won, bus.tick_end, bus.score_valid);
      end
    end
    bus.user_input = '0; bus.lights = '0;
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    m_score = 0; m_combo = 0;
    checks++;
    if (bus.score !== 8'd0 || bus.won !== 1'b0 || bus.combo !== 6'd0 || bus.state_dbg !== judge_pkg::PLAY) begin
      errors++;
      $display("FAIL clear_restart: score=%0d won=%b combo=%0d state=%0d required 0/0/0/PLAY",
               bus.score, bus.won, bus.combo, bus.state_dbg);
    end
  endtask

  task automatic test_bonus();
    logic [7:0] s, es, prev; logic [5:0] c, ec; logic v1, v2, w;
    for (int t = 0; t < 8; t++) begin
      play_tick(32'h0000_0001, 4'b0001, 4, 4'b0000, s, c, v1, v2, w);
      model_tick(32'h0000_0001, 4'b0001, 4'b0000);
      void'(exp_q.pop_front()); void'(exp_combo_q.pop_front());
    end
    checks++; if (c !== 6'd8) begin errors++; $display("FAIL bonus_combo_setup: got %0d required 8", c); end
    prev = s;
    play_tick(32'h0000_0002, 4'b0001, 9, 4'b0000, s, c, v1, v2, w);
    model_tick(32'h0000_0002, 4'b0001, 4'b0000);
    es = exp_q.pop_front(); ec = exp_combo_q.pop_front();
    checks++; if (s !== es || int'(s) - int'(prev) !== (BONUS ? 3 : 2)) begin
      errors++; $display("FAIL bonus_perfect: score %0d->%0d required %0d", prev, s, es);
    end
    checks++; if (c !== ec || c !== 6'd9) begin errors++; $display("FAIL bonus_combo: got %0d required 9", c); end
  endtask

  initial begin
    bus.clear = 1'b0; bus.user_input = '0; bus.lights = '0; bus.off_edge = '0;
    test_reset();
    test_good_single();
    test_perfect_vs_miss();
    test_floor();
    test_press_window();
    test_random();
    test_mid_reset();
    test_win();
    test_bonus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
